// File: rtl/ps2_host_tx_if.sv
// Host-transmitter bundle: byte handshake from the keyboard controller,
// raw PS/2 pin levels from the pads and the open-drain pull-low enables.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clock_in;
    logic       ps2_data_in;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;

    // Controller / pad side of the transmitter.
    modport master (
        output tx_data,
        output tx_valid,
        output ps2_clock_in,
        output ps2_data_in,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_error,
        input  ps2_clock_oe,
        input  ps2_data_oe
    );

    // The transmitter itself.
    modport slave (
        input  tx_data,
        input  tx_valid,
        input  ps2_clock_in,
        input  ps2_data_in,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_error,
        output ps2_clock_oe,
        output ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// over the shared open-drain clock/data pair using pull-low enables.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | bus released, tx_ready high, waiting for a request
// S_INHIBIT   | host holds clock low to claim the bus
// S_START     | host holds clock and data low (start bit) before release
// S_BITS      | device clocks; data/parity/stop driven after each fall
// S_ACK       | bus released, device ack sampled on the next fall
// S_WAIT_IDLE | waiting for device to release both lines
// S_DONE      | one-cycle tx_done pulse
// S_ERR       | one-cycle tx_error pulse (nack or timeout)
module ps2_host_tx #(
    parameter int P_INHIBIT_CYCLES = 5000,
    parameter int P_START_CYCLES   = 16,
    parameter int P_TIMEOUT_CYCLES = 750000
) (
    input  logic         clk_in,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    // Terminal-count values; the shared counter starts at 0 on state entry.
    localparam logic [19:0] INHIBIT_LAST = 20'(P_INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(P_START_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(P_TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [1:0]  clk_sync_q;
    logic [1:0]  data_sync_q;
    logic        clk_prev_q;
    logic        fall_q;
    logic        fall_d;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [3:0]  bit_idx_q;
    logic [19:0] cnt_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        clock_oe_q;
    logic        data_oe_q;

    logic        clk_s;
    logic        data_s;
    logic        timeout;

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign fall_d  = clk_prev_q & ~clk_s;
    assign timeout = (cnt_q == TIMEOUT_LAST);

    assign bus.tx_ready     = ready_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_done      = done_q;
    assign bus.tx_error     = error_q;
    assign bus.ps2_clock_oe = clock_oe_q;
    assign bus.ps2_data_oe  = data_oe_q;

    // Pin synchronizers and registered falling-edge detect (pin edge to
    // fall_q is three cycles). Reset to the released (high) level so a
    // reset never fabricates a fall.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clock_in};
            data_sync_q <= {data_sync_q[0], bus.ps2_data_in};
            clk_prev_q  <= clk_s;
            fall_q      <= fall_d;
        end
    end

    // Frame sequencer with registered handshake and bus-enable outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            bit_idx_q  <= 4'd0;
            cnt_q      <= 20'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clock_oe_q <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // ready_q is high throughout IDLE, so tx_valid alone accepts.
                    if (bus.tx_valid) begin
                        shift_q    <= bus.tx_data;
                        parity_q   <= ~^bus.tx_data;
                        cnt_q      <= 20'd0;
                        clock_oe_q <= 1'b1;
                        data_oe_q  <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (cnt_q == INHIBIT_LAST) begin
                        cnt_q     <= 20'd0;
                        data_oe_q <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end

                S_START: begin
                    // Releasing the clock hands the bus to the device; the start
                    // bit stays driven until the first device fall.
                    if (cnt_q == START_LAST) begin
                        cnt_q      <= 20'd0;
                        bit_idx_q  <= 4'd0;
                        clock_oe_q <= 1'b0;
                        state_q    <= S_BITS;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end

                S_BITS: begin
                    if (fall_q) begin
                        cnt_q     <= 20'd0;
                        bit_idx_q <= bit_idx_q + 4'd1;
                        if (bit_idx_q < 4'd8) begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end else if (bit_idx_q == 4'd8) begin
                            data_oe_q <= ~parity_q;
                        end else begin
                            data_oe_q <= 1'b0;
                            state_q   <= S_ACK;
                        end
                    end else if (timeout) begin
                        cnt_q      <= 20'd0;
                        clock_oe_q <= 1'b0;
                        data_oe_q  <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end

                S_ACK: begin
                    // Device acks by holding data low across this clock pulse.
                    if (fall_q) begin
                        cnt_q <= 20'd0;
                        if (!data_s) begin
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end else if (timeout) begin
                        cnt_q   <= 20'd0;
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        cnt_q   <= 20'd0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (fall_q) begin
                        cnt_q <= 20'd0;
                    end else if (timeout) begin
                        cnt_q   <= 20'd0;
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end

                S_DONE, S_ERR: begin
                    // tx_ready returns the cycle after the completion pulse.
                    cnt_q      <= 20'd0;
                    clock_oe_q <= 1'b0;
                    data_oe_q  <= 1'b0;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    cnt_q      <= 20'd0;
                    clock_oe_q <= 1'b0;
                    data_oe_q  <= 1'b0;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of command bytes run through a 40/40-cycle
// device model, plus hand-written timeout, held-request and reset sequences.
module tb_ps2_host_tx;

    localparam int NV = 5;

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        logic [10:0] frame;   // data_oe seen at each device rising edge, start first
        int          done;
        int          err;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int excl_cnt = 0;

    vec_t vecs [NV];

    ps2_host_tx_if bus ();

    assign bus.ps2_clock_in = ~(bus.ps2_clock_oe | dev_clk_low);
    assign bus.ps2_data_in  = ~(bus.ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .P_INHIBIT_CYCLES (100),
        .P_START_CYCLES   (16),
        .P_TIMEOUT_CYCLES (2000)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #10 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_error) err_cnt++;
        if (bus.tx_done && bus.tx_error) excl_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!bus.tx_ready && k < 5000) begin
            @(negedge clk_in);
            k++;
        end
        check(name, 32'(bus.tx_ready), 32'd1);
    endtask

    task automatic wait_release(input string name);
        int k = 0;
        while (bus.ps2_clock_oe && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        check(name, 32'(bus.ps2_clock_oe), 32'd0);
    endtask

    // One-cycle request; checks accept, inhibit and start timing. Returns at
    // the first negedge after the host releases the clock.
    task automatic request(input logic [7:0] d);
        int k;
        wait_ready("req_ready");
        @(negedge clk_in);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk_in);
        bus.tx_valid = 1'b0;
        check("accept_outputs",
              32'({bus.ps2_clock_oe, bus.tx_busy, bus.ps2_data_oe, bus.tx_ready}), 32'b1100);
        k = 1;
        while (!bus.ps2_data_oe && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        check("inhibit_len", 32'(k), 32'd101);
        while (bus.ps2_clock_oe && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        check("start_len", 32'(k), 32'd117);
    endtask

    // Device side: 10 clock pulses for d0..stop, then the ack pulse.
    task automatic dev_frame(input bit ack, output logic [10:0] frame, output logic [7:0] rx);
        frame    = '0;
        rx       = '0;
        frame[0] = bus.ps2_data_oe;
        repeat (20) @(negedge clk_in);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk_in);
            dev_clk_low = 1'b0;
            frame[i] = bus.ps2_data_oe;
            if (i <= 8) rx[i-1] = bus.ps2_data_in;
            repeat (40) @(negedge clk_in);
        end
        repeat (20) @(negedge clk_in);
        dev_data_low = ack;
        repeat (20) @(negedge clk_in);
        dev_clk_low = 1'b1;
        repeat (40) @(negedge clk_in);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk_in);
        dev_data_low = 1'b0;
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  rx;
        int d0, e0, k;

        // data, ack, frame = {stop, ~parity, ~d7..~d0, start}
        vecs[0] = '{8'hED, 1'b1, 11'h025, 1, 0};
        vecs[1] = '{8'h07, 1'b1, 11'h3F1, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 11'h0B5, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 11'h1FF, 1, 0};
        vecs[4] = '{8'h3C, 1'b1, 11'h187, 1, 0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        repeat (3) @(negedge clk_in);
        check("reset_outputs", 32'({bus.tx_ready, bus.tx_busy, bus.tx_done, bus.tx_error,
                                    bus.ps2_clock_oe, bus.ps2_data_oe}), 32'b100000);
        reset = 1'b0;
        @(negedge clk_in);
        check("post_reset_outputs", 32'({bus.tx_ready, bus.tx_busy, bus.tx_done, bus.tx_error,
                                         bus.ps2_clock_oe, bus.ps2_data_oe}), 32'b100000);

        for (int i = 0; i < NV; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            request(vecs[i].data);
            dev_frame(vecs[i].ack, fr, rx);
            check($sformatf("frame[%0d]", i), 32'(fr), 32'(vecs[i].frame));
            check($sformatf("dev_byte[%0d]", i), 32'(rx), 32'(vecs[i].data));
            wait_ready($sformatf("end_ready[%0d]", i));
            repeat (2) @(negedge clk_in);
            check($sformatf("done_pulses[%0d]", i), 32'(done_cnt - d0), 32'(vecs[i].done));
            check($sformatf("error_pulses[%0d]", i), 32'(err_cnt - e0), 32'(vecs[i].err));
            check($sformatf("oe_idle[%0d]", i), 32'({bus.ps2_clock_oe, bus.ps2_data_oe}), 32'd0);
        end

        // Device never clocks after release: timeout from BITS entry.
        d0 = done_cnt;
        e0 = err_cnt;
        request(8'h3C);
        k = 0;
        while (!bus.tx_error && k < 3000) begin
            @(negedge clk_in);
            k++;
        end
        check_range("timeout_len", k, 1999, 2001);
        check("timeout_oe", 32'({bus.ps2_clock_oe, bus.ps2_data_oe}), 32'd0);
        @(negedge clk_in);
        check("timeout_ready", 32'({bus.tx_ready, bus.tx_busy}), 32'b10);
        check("timeout_pulses", 32'({16'(done_cnt - d0), 16'(err_cnt - e0)}), 32'h0000_0001);

        // tx_valid held high: 0xFF sent, then 0x55 accepted on the first ready cycle.
        d0 = done_cnt;
        wait_ready("held_ready0");
        @(negedge clk_in);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk_in);
        check("held_busy", 32'(bus.tx_busy), 32'd1);
        bus.tx_data = 8'h55;
        wait_release("held_release0");
        dev_frame(1'b1, fr, rx);
        check("held_frame_ff", 32'(fr), 32'h001);
        check("held_byte_ff", 32'(rx), 32'hFF);
        k = 0;
        while (!bus.tx_ready && k < 200) begin
            @(negedge clk_in);
            k++;
        end
        check("held_ready1", 32'(bus.tx_ready), 32'd1);
        @(negedge clk_in);
        check("held_accept", 32'({bus.tx_busy, bus.ps2_clock_oe, bus.tx_ready}), 32'b110);
        bus.tx_valid = 1'b0;
        check("held_done_ff", 32'(done_cnt - d0), 32'd1);
        wait_release("held_release1");
        dev_frame(1'b1, fr, rx);
        check("held_frame_55", 32'(fr), 32'h155);
        check("held_byte_55", 32'(rx), 32'h55);
        wait_ready("held_ready2");
        repeat (2) @(negedge clk_in);
        check("held_done_55", 32'(done_cnt - d0), 32'd2);

        // Reset after four device falls, then a clean 0xF4.
        d0 = done_cnt;
        e0 = err_cnt;
        request(8'h00);
        repeat (20) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk_in);
            dev_clk_low = 1'b0;
            repeat (40) @(negedge clk_in);
        end
        check("pre_reset_data_oe", 32'(bus.ps2_data_oe), 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_async", 32'({bus.ps2_clock_oe, bus.ps2_data_oe, bus.tx_busy, bus.tx_ready}),
                 32'b0001);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (50) @(negedge clk_in);
        check("reset_no_pulse", 32'({16'(done_cnt - d0), 16'(err_cnt - e0)}), 32'd0);
        request(8'hF4);
        dev_frame(1'b1, fr, rx);
        check("f4_frame", 32'(fr), 32'h217);
        check("f4_byte", 32'(rx), 32'hF4);
        wait_ready("f4_ready");
        repeat (2) @(negedge clk_in);
        check("f4_done", 32'({16'(done_cnt - d0), 16'(err_cnt - e0)}), 32'h0001_0000);

        check("done_error_exclusive", 32'(excl_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the keyboard over the same open-drain ps2_clock/ps2_data pair that the scancode receiver listens on. It sits beside the keyboard receiver under the keyboard controller. It drives the bus only through active-high pull-low enables, and it asserts tx_busy so the controller can ignore receiver output during a transmission.

## Interface
- P_INHIBIT_CYCLES, 5000: cycles clock is held low before the request (100 µs at 50 MHz).
- P_START_CYCLES, 16: cycles data and clock are both held low before clock release.
- P_TIMEOUT_CYCLES, 750000: maximum cycles spent waiting in any device-driven state (15 ms).

- clk_in  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; tx_data is accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: device acknowledged and bus returned to idle.
- tx_error  out  1  one-cycle pulse: ack missing or timeout.
- ps2_clock_in  in  1  raw pin level of ps2_clock.
- ps2_data_in  in  1  raw pin level of ps2_data.
- ps2_clock_oe  out  1  1 = pull clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull data low; 0 = release.

## Operation
- **Input sync:** both pin inputs pass through 2-flop synchronizers.
  - fall = (previous synced clock == 1) && (current synced clock == 0).
  - Pin edge to fall is 3 cycles.
- **Frame:** the accepted byte is latched into an 8-bit shift register. Parity is odd: parity = ~^tx_data. Bits go LSB first.
- **States:**
  - IDLE: both oe = 0; tx_ready = 1. On accept → INHIBIT, counter cleared.
  - INHIBIT: clock_oe = 1, data_oe = 0 for P_INHIBIT_CYCLES cycles → START.
  - START: clock_oe = 1, data_oe = 1 (start bit) for P_START_CYCLES cycles → BITS, bit index = 0.
  - BITS: clock_oe = 0. On each fall, data_oe is set as follows:
    - falls 1–8: data_oe = ~data bit 0–7.
    - fall 9: data_oe = ~parity.
    - fall 10: data_oe = 0 (stop bit) → ACK.
  - ACK: both oe = 0. On the next fall, sample synced data:
    - 0 → WAIT_IDLE.
    - 1 → ERR.
  - WAIT_IDLE: when synced clock == 1 and synced data == 1 → DONE.
  - DONE: tx_done = 1 for one cycle → IDLE.
  - ERR: tx_error = 1 for one cycle, both oe = 0 → IDLE.
- **Timeout:** a 20-bit counter clears on every fall and on every state entry. It counts in BITS, ACK and WAIT_IDLE. Reaching P_TIMEOUT_CYCLES → ERR.
- tx_valid is ignored while busy. No queueing is done; the controller must wait for tx_ready.
- The start bit counts as bit 0 of the frame: bits are start, d0–d7, parity, stop, then the device ack.

## Timing
- **Reset values:** state = IDLE, tx_ready = 1, tx_busy = 0, tx_done = 0, tx_error = 0, ps2_clock_oe = 0, ps2_data_oe = 0. The shift register and counters clear to 0.
- **Reset mid-frame:** both oe deassert asynchronously and immediately; no pulse is emitted.
- **Accept:**
  - Cycle N: accept.
  - Cycle N+1: clock_oe = 1 and tx_busy = 1.
  - Cycle N+1+P_INHIBIT_CYCLES: data_oe = 1.
  - Cycle N+1+P_INHIBIT_CYCLES+P_START_CYCLES: clock_oe = 0.
- **Data update:** data_oe changes in the cycle after fall is detected, while the device clock is low. The device samples on the rising edge.
- **Error vs. done:** tx_done and tx_error are mutually exclusive. The pulse appears exactly 1 cycle after the deciding event. tx_ready rises the cycle after the pulse.
- **Glitches:** a fall during INHIBIT or START (the host drives clock low there) is ignored.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Benches use P_INHIBIT_CYCLES = 100, P_START_CYCLES = 16, P_TIMEOUT_CYCLES = 2000, and a device model that clocks at 40 cycles low / 40 cycles high.

1. **Send 0xED, device acks.**
   - Required: data_oe sampled at the rising edges = start 1, then ~{1,0,1,1,0,1,1,1}, then ~parity(1) = 0, then stop 0. The device sees bits 0xED with parity 1.
   - Then exactly one tx_done, no tx_error, and tx_ready = 1 afterwards.
2. **Send 0x07.**
   - Required: parity bit 0, so data_oe = 1 during the parity slot. tx_done pulses.
3. **Device leaves data high at the ack fall.**
   - Required: tx_error pulses once, tx_done stays 0, and both oe = 0.
4. **Device never clocks after clock release.**
   - Required: tx_error exactly 2000 cycles after BITS entry (±1), then IDLE.
5. **tx_valid held high with 0x55 during a 0xFF transfer.**
   - Required: only 0xFF is sent. 0x55 is accepted on the first cycle tx_ready = 1.
6. **reset asserted mid-BITS, after 4 falls.**
   - Required: oe = 0 in the same cycle, tx_busy = 0, and no done or error pulse.
   - A following 0xF4 then transfers correctly.
